// File: rtl/kbonacci_pkg.sv
// kbonacci_pkg: definitions shared by the k-bonacci stream generator.
//   state_t   : controller states (IDLE, RUN)
//   ORDER_MIN : smallest supported recurrence order
//   ORDER_MAX : largest supported recurrence order
package kbonacci_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int ORDER_MIN = 2;
  localparam int ORDER_MAX = 4;

endpackage

// File: rtl/kbonacci_history.sv
// kbonacci_history: ORDER-deep term history and next-term adder.
// Optional build macro: KBONACCI_SAT_EN (clamp out-of-range terms to
// all-ones and hold all-ones afterwards; otherwise terms wrap).
// Ports:
//   clk, resetn  : clock, synchronous active-low reset
//   load         : start a sequence (term 0 = seed_a, older terms = 0)
//   advance      : shift in the next term
//   seed_a/b     : terms 0 and 1
//   term         : term currently presented
//   ovf_event    : advance is loading a term that does not fit DATA_WIDTH
module kbonacci_history #(
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned ORDER      = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic                  advance,
  input  logic [DATA_WIDTH-1:0] seed_a,
  input  logic [DATA_WIDTH-1:0] seed_b,
  output logic [DATA_WIDTH-1:0] term,
  output logic                  ovf_event
);

  // hist[0] is the presented term, hist[ORDER-1] the oldest one kept.
  logic [DATA_WIDTH-1:0] hist [ORDER];
  logic [DATA_WIDTH-1:0] seed_b_r;
  logic                  use_seed_b;
  logic [DATA_WIDTH+1:0] sum;
  logic                  out_of_range;
  logic [DATA_WIDTH-1:0] next_term;
`ifdef KBONACCI_SAT_EN
  logic                  sat_r;
`endif

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < ORDER; i++) begin
      sum = sum + {2'b00, hist[i]};
    end
  end

  // Term 1 is seed_b rather than a sum, so it can never be out of range.
  assign out_of_range = !use_seed_b && (sum[DATA_WIDTH+1:DATA_WIDTH] != 2'b00);
  assign ovf_event    = advance && out_of_range;
  assign term         = hist[0];

  always_comb begin
    next_term = sum[DATA_WIDTH-1:0];
    if (use_seed_b) begin
      next_term = seed_b_r;
    end
`ifdef KBONACCI_SAT_EN
    else if (sat_r || out_of_range) begin
      next_term = '1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < ORDER; i++) hist[i] <= '0;
      seed_b_r   <= '0;
      use_seed_b <= 1'b0;
`ifdef KBONACCI_SAT_EN
      sat_r      <= 1'b0;
`endif
    end else if (load) begin
      hist[0] <= seed_a;
      for (int unsigned i = 1; i < ORDER; i++) hist[i] <= '0;
      seed_b_r   <= seed_b;
      use_seed_b <= 1'b1;
`ifdef KBONACCI_SAT_EN
      sat_r      <= 1'b0;
`endif
    end else if (advance) begin
      hist[0] <= next_term;
      for (int unsigned i = 1; i < ORDER; i++) hist[i] <= hist[i-1];
      use_seed_b <= 1'b0;
`ifdef KBONACCI_SAT_EN
      sat_r      <= sat_r | out_of_range;
`endif
    end
  end

endmodule

// File: rtl/kbonacci_stream_gen.sv
// kbonacci_stream_gen: streams a k-bonacci sequence over a valid/ready port.
// Optional build macro: KBONACCI_SAT_EN (saturate instead of wrap).
// Ports:
//   clk, resetn     : clock, synchronous active-low reset
//   start           : begin a sequence (sampled in IDLE only)
//   seed_a, seed_b  : terms 0 and 1
//   count           : number of terms to emit, 0 = unbounded
//   out_valid/ready : output handshake
//   out_data        : current term
//   out_last        : current term is the final one
//   busy            : sequence in progress
//   overflow        : sticky, some emitted term exceeded DATA_WIDTH
module kbonacci_stream_gen
  import kbonacci_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ORDER      = 2,
  parameter int COUNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed_a,
  input  logic [DATA_WIDTH-1:0] seed_b,
  input  logic [COUNT_W-1:0]    count,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  overflow
);

  if (ORDER < ORDER_MIN || ORDER > ORDER_MAX) begin : g_bad_order
    $error("kbonacci_stream_gen: ORDER must be within 2..4");
  end

  state_t               state, state_next;
  logic                 load, advance;
  logic [COUNT_W-1:0]   remaining;
  logic                 unbounded;
  logic                 overflow_r;
  logic                 ovf_event;

  kbonacci_history #(
    .DATA_WIDTH (DATA_WIDTH),
    .ORDER      (ORDER)
  ) u_history (
    .clk       (clk),
    .resetn    (resetn),
    .load      (load),
    .advance   (advance),
    .seed_a    (seed_a),
    .seed_b    (seed_b),
    .term      (out_data),
    .ovf_event (ovf_event)
  );

  // remaining counts terms still to emit including the presented one.
  assign out_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign out_last  = (state == RUN) && !unbounded && (remaining == COUNT_W'(1));
  assign overflow  = overflow_r;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (out_ready) begin
          if (out_last) state_next = IDLE;
          else          advance    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      remaining  <= '0;
      unbounded  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        remaining  <= count;
        unbounded  <= (count == '0);
        overflow_r <= 1'b0;
      end else if (advance) begin
        remaining <= remaining - COUNT_W'(1);
        if (ovf_event) overflow_r <= 1'b1;
      end
    end
  end

endmodule

// File: doc/kbonacci_stream_gen.md
KBONACCI_STREAM_GEN -- requirements
Module: kbonacci_stream_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of seeds and output terms.
REQ-002 SHALL have parameter ORDER, default 2, legal range 2..4: number of preceding terms summed per new term.
REQ-003 SHALL have parameter COUNT_W, default 16: width of the term-count input.
REQ-004 SHALL have port clk, input, 1: clock; all logic on its rising edge.
REQ-005 SHALL have port resetn, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port start, input, 1: request to begin a new sequence.
REQ-007 SHALL have ports seed_a and seed_b, input, DATA_WIDTH each: terms 0 and 1.
REQ-008 SHALL have port count, input, COUNT_W: number of terms to emit; 0 means unbounded.
REQ-009 SHALL have port out_valid, output, 1: out_data holds a valid term.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the term.
REQ-011 SHALL have port out_data, output, DATA_WIDTH: current term.
REQ-012 SHALL have port out_last, output, 1: the current term is the final one.
REQ-013 SHALL have port busy, output, 1: a sequence is in progress.
REQ-014 SHALL have port overflow, output, 1: sticky flag set when any emitted term exceeded DATA_WIDTH.

Function
REQ-015 SHALL implement the FSM states IDLE and RUN; busy=1 exactly in RUN.
REQ-016 SHALL, in IDLE with start=1, sample seed_a, seed_b and count, clear overflow, and enter RUN; out_valid=1 with out_data=seed_a on the next cycle.
REQ-017 SHALL ignore start while in RUN.
REQ-018 SHALL emit seed_a as term 0 and seed_b as term 1; for n>=2, term n = sum of terms n-1 .. n-ORDER, with terms of negative index equal to 0.
REQ-019 SHALL advance to the next term only on the handshake out_valid && out_ready; out_valid=1 continuously in RUN.
REQ-020 SHALL hold out_data, out_last and overflow stable while out_valid=1 and out_ready=0.
REQ-021 SHALL compute each sum at DATA_WIDTH+2 bits and set overflow in the same cycle the first out-of-range term is presented.
REQ-022 SHALL assert out_last with the term numbered count-1 when count!=0; count=1 emits only seed_a with out_last=1.
REQ-023 SHALL return to IDLE with out_valid=0 in the cycle after the handshake of an out_last term.
REQ-024 SHALL never assert out_last when count=0; the sequence then runs until reset.
REQ-025 SHALL keep overflow at its value in IDLE until the next accepted start.

Reset
REQ-026 SHALL, with resetn=0 at a clock edge, enter IDLE and set out_valid=0, out_last=0, busy=0, overflow=0, and out_data=0, including mid-sequence.
REQ-027 SHALL give resetn priority over start and handshake in the same cycle.

Configuration
REQ-028 SHALL, with macro KBONACCI_SAT_EN defined, clamp any out-of-range term to all-ones, and then hold all-ones for every later term.
REQ-029 SHALL, without KBONACCI_SAT_EN, wrap out-of-range terms modulo 2^DATA_WIDTH; overflow behaves the same in both builds.

Structure
REQ-030 SHALL take the FSM state enum and the ORDER_MIN=2 and ORDER_MAX=4 constants from the shared package kbonacci_pkg.
REQ-031 SHALL place the ORDER-deep history shift register and the adder in the sub-module kbonacci_history, instantiated once.
REQ-032 SHALL flag an elaboration error for ORDER outside 2..4.

Verification
REQ-033 SHALL cover DATA_WIDTH=8, ORDER=2, seeds 1,1, count=14, ready=1 -> outputs 1,1,2,3,5,8,13,21,34,55,89,144,233,121; overflow=1 from term 13; out_last only on 121.
REQ-034 SHALL cover the same stimulus with KBONACCI_SAT_EN defined -> term 13 = 255 with overflow=1.
REQ-035 SHALL cover ORDER=3, seeds 1,1, count=6 -> outputs 1,1,2,4,7,13 with out_last on 13; busy=0 on the following cycle.
REQ-036 SHALL cover ORDER=2, seeds 2,3, out_ready=0 for 3 cycles at term 2 -> out_data held at 5 throughout; next accepted term is 8.
REQ-037 SHALL cover start pulsed during RUN -> ignored; resetn=0 mid-sequence -> IDLE next cycle with all outputs 0; a new start with seeds 1,1 then yields 1,1,2.
REQ-038 SHALL cover count=0, seeds 0,1, ORDER=2 -> 0,1,1,2,3,... with no out_last after 20 handshakes.
